// File: rtl/load_store_unit.sv
// Load/store unit: runs one load or store per request as little-endian byte beats on a
// req/ack data bus, with alignment/conflict checking, ack timeout and load extension.
module load_store_unit #(
    parameter int ADDR_WIDTH  = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            read,
    input  logic [1:0]            write,
    input  logic [2:0]            func3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           store_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           load_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_ack
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_BEAT,
        S_DONE
    } state_t;

    state_t                  state_reg, state_next;
    logic [1:0]              read_reg, write_reg;
    logic                    zext_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [31:0]             store_data_reg;
    logic [1:0]              beat_reg;
    logic [TW-1:0]           wait_reg;
    logic                    err_reg;
    logic [31:0]             rbuf_reg;
    logic [31:0]             load_data_reg;

    logic [1:0]              size;
    logic [1:0]              last_idx;
    logic                    bad_req;
    logic                    last_beat;
    logic                    timeout_hit;
    logic [31:0]             assembled;
    logic [31:0]             extended;

    // A request carries one size: whichever of read/write is non-zero.
    assign size      = (read_reg != 2'b00) ? read_reg : write_reg;
    assign last_idx  = (size == 2'b11) ? 2'd3 : ((size == 2'b10) ? 2'd1 : 2'd0);
    assign bad_req   = ((read_reg != 2'b00) && (write_reg != 2'b00))
                     || ((size == 2'b10) && addr_reg[0])
                     || ((size == 2'b11) && (addr_reg[1:0] != 2'b00));
    assign last_beat = (beat_reg == last_idx);
    assign timeout_hit = (ACK_TIMEOUT != 0) && (state_reg == S_BEAT) && !mem_ack
                       && (wait_reg == TO_LAST);

    // Merge the byte arriving this cycle so the final beat lands in the same edge as DONE.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign assembled[8*gi +: 8] = (beat_reg == 2'(gi)) ? mem_rdata : rbuf_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        extended = assembled;
        case (size)
            2'b01:   extended = zext_reg ? {24'h0, assembled[7:0]}
                                         : {{24{assembled[7]}}, assembled[7:0]};
            2'b10:   extended = zext_reg ? {16'h0, assembled[15:0]}
                                         : {{16{assembled[15]}}, assembled[15:0]};
            default: extended = assembled;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_CHECK;
            S_CHECK: state_next = (bad_req || (size == 2'b00)) ? S_DONE : S_BEAT;
            S_BEAT:  if ((mem_ack && last_beat) || timeout_hit) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_reg       <= 2'b00;
            write_reg      <= 2'b00;
            zext_reg       <= 1'b0;
            addr_reg       <= '0;
            store_data_reg <= 32'h0;
            beat_reg       <= 2'd0;
            wait_reg       <= '0;
            err_reg        <= 1'b0;
            rbuf_reg       <= 32'h0;
            load_data_reg  <= 32'h0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        read_reg       <= read;
                        write_reg      <= write;
                        zext_reg       <= func3[2];
                        addr_reg       <= addr;
                        store_data_reg <= store_data;
                    end
                end
                S_CHECK: begin
                    err_reg  <= bad_req;
                    beat_reg <= 2'd0;
                    wait_reg <= '0;
                end
                S_BEAT: begin
                    if (mem_ack) begin
                        rbuf_reg <= assembled;
                        wait_reg <= '0;
                        if (last_beat) begin
                            if (read_reg != 2'b00) load_data_reg <= extended;
                        end else begin
                            beat_reg <= beat_reg + 2'd1;
                        end
                    end else if (timeout_hit) begin
                        err_reg <= 1'b1;
                    end else begin
                        wait_reg <= wait_reg + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = (state_reg != S_IDLE);
        done      = (state_reg == S_DONE);
        error     = (state_reg == S_DONE) && err_reg;
        mem_req   = (state_reg == S_BEAT);
        mem_we    = (state_reg == S_BEAT) && (write_reg != 2'b00);
        mem_addr  = addr_reg + {{(ADDR_WIDTH-2){1'b0}}, beat_reg};
        mem_wdata = store_data_reg[{beat_reg, 3'b000} +: 8];
        load_data = load_data_reg;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: bus responder with a byte memory, randomized requests and
// ack delays, checked against a transaction-level model of sizes, alignment and timeout.
module tb_load_store_unit;

    localparam int AW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    read = 2'b00;
    logic [1:0]    write = 2'b00;
    logic [2:0]    func3 = 3'b000;
    logic [AW-1:0] addr = '0;
    logic [31:0]   store_data = 32'h0;
    logic          busy, done, error, mem_req, mem_we;
    logic [31:0]   load_data;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata = 8'h0;
    logic          mem_ack = 1'b0;

    load_store_unit #(.ADDR_WIDTH(AW), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .read(read), .write(write), .func3(func3),
        .addr(addr), .store_data(store_data), .busy(busy), .done(done), .error(error),
        .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [int unsigned];

    // Transaction context shared with the bus responder
    bit          cur_active = 1'b0;
    bit          cur_we = 1'b0;
    logic [31:0] cur_addr = 32'h0;
    logic [31:0] cur_sd = 32'h0;
    int          cur_nbeats = 0;
    int          dly [4];
    int          resp_beat = 0;
    int          resp_wait = 0;
    logic [31:0] exp_load = 32'h0;

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        logic [31:0] h;
        if (mem.exists(a)) return mem[a];
        h = a * 32'd37 + 32'd11;
        return h[7:0];
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input int nb, input bit zext);
        longint v;
        longint half_range;
        v = longint'(raw);
        if (nb < 4 && !zext) begin
            half_range = longint'(1) << (8 * nb - 1);
            if (v >= half_range) v = v - 2 * half_range;
        end
        return v[31:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare-and-respond: every cycle the bus is requested, the beat must match the model.
    always @(negedge clk) begin
        logic [31:0] exp_a;
        if (mem_req) begin
            checks++;
            if (!cur_active || resp_beat >= cur_nbeats) begin
                errors++;
                $display("FAIL unexpected_req: mem_req=1 addr=%h active=%0d beat=%0d",
                         mem_addr, cur_active, resp_beat);
                mem_ack = 1'b0;
            end else begin
                exp_a = cur_addr + 32'(resp_beat);
                if (mem_addr !== exp_a || mem_we !== cur_we
                    || (cur_we && mem_wdata !== cur_sd[8*resp_beat +: 8])) begin
                    errors++;
                    $display("FAIL beat: got addr=%h we=%b wd=%h expected addr=%h we=%b wd=%h",
                             mem_addr, mem_we, mem_wdata, exp_a, cur_we, cur_sd[8*resp_beat +: 8]);
                end
                if (resp_wait == dly[resp_beat]) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_rd(exp_a);
                    if (cur_we) mem[exp_a] = cur_sd[8*resp_beat +: 8];
                    resp_beat++;
                    resp_wait = 0;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 8'($urandom);
                    resp_wait++;
                end
            end
        end else begin
            mem_ack   = ($urandom % 4 == 0);
            mem_rdata = 8'($urandom);
        end
    end

    task automatic run_txn(input logic [1:0] rd, input logic [1:0] wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd, input int dmode,
                           input int lit_lat, input bit use_lit, input logic [31:0] lit_data);
        logic [1:0]  size;
        int          nb, lat, exp_lat, k;
        bit          bad, exp_err, got;
        logic [31:0] raw;
        size = (rd != 0) ? rd : wr;
        nb   = (size == 1) ? 1 : (size == 2) ? 2 : (size == 3) ? 4 : 0;
        bad  = (rd != 0 && wr != 0) || (size == 2 && a[0]) || (size == 3 && a[1:0] != 0);
        for (int i = 0; i < 4; i++)
            dly[i] = (dmode >= 0) ? dmode
                   : (($urandom % 8 == 0) ? 4 + int'($urandom % 3) : int'($urandom % 3));
        exp_err = bad;
        if (bad || nb == 0) begin
            exp_lat = 2;
        end else begin
            lat = 1;
            for (int i = 0; i < nb; i++) begin
                if (dly[i] >= TO) begin
                    lat += TO;
                    exp_err = 1'b1;
                    break;
                end
                lat += dly[i] + 1;
            end
            exp_lat = lat + 1;
        end
        if (rd != 0 && !exp_err) begin
            raw = 32'h0;
            for (int i = 0; i < nb; i++) raw |= 32'(mem_rd(a + 32'(i))) << (8 * i);
            exp_load = extend(raw, nb, f3[2]);
        end

        @(negedge clk);
        cur_active = !bad && nb != 0;
        cur_we     = (wr != 0);
        cur_addr   = a;
        cur_sd     = sd;
        cur_nbeats = nb;
        resp_beat  = 0;
        resp_wait  = 0;
        read = rd; write = wr; func3 = f3; addr = a; store_data = sd; start = 1'b1;

        k = 0;
        got = 1'b0;
        while (k < 100) begin
            @(negedge clk);
            k++;
            if (done) begin
                got = 1'b1;
                break;
            end
            chk("busy_during", {63'h0, busy}, 64'h1);
            // Requests while busy must be ignored
            start = ($urandom % 3 == 0);
            read = 2'($urandom); write = 2'($urandom); addr = $urandom; store_data = $urandom;
        end
        start = 1'b0;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout: no done within 100 cycles (rd=%0d wr=%0d addr=%h)", rd, wr, a);
        end else begin
            chk("latency", 64'(k), 64'(exp_lat));
            if (lit_lat >= 0) chk("latency_lit", 64'(k), 64'(lit_lat));
            chk("error", {63'h0, error}, {63'h0, exp_err});
            chk("busy_at_done", {63'h0, busy}, 64'h1);
            chk("load_data", {32'h0, load_data}, {32'h0, exp_load});
            if (use_lit) chk("load_data_lit", {32'h0, load_data}, {32'h0, lit_data});
            $display("txn rd=%0d wr=%0d f3=%0d addr=%h sd=%h err=%0d load=%h lat=%0d",
                     rd, wr, f3, a, sd, error, load_data, k);
            @(negedge clk);
            chk("done_pulse_idle", {62'h0, done, busy}, 64'h0);
        end
        cur_active = 1'b0;
    endtask

    initial begin
        int          r, k;
        logic [1:0]  sz;
        logic [31:0] a;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_done_err", {62'h0, done, error}, 64'h0);
        chk("rst_req_we", {62'h0, mem_req, mem_we}, 64'h0);
        chk("rst_addr_wdata", {24'h0, mem_addr, mem_wdata}, 64'h0);
        chk("rst_load", {32'h0, load_data}, 64'h0);
        rst = 1'b0;

        mem[32'h103] = 8'h80;
        run_txn(2'b01, 2'b00, 3'b000, 32'h103, 32'h0, 0, 3, 1'b1, 32'hFFFFFF80);
        mem[32'h200] = 8'h34;
        mem[32'h201] = 8'h92;
        run_txn(2'b10, 2'b00, 3'b101, 32'h200, 32'h0, 0, 4, 1'b1, 32'h00009234);
        run_txn(2'b10, 2'b00, 3'b001, 32'h200, 32'h0, 0, 4, 1'b1, 32'hFFFF9234);
        run_txn(2'b00, 2'b11, 3'b010, 32'h40, 32'hDEADBEEF, 2, 14, 1'b1, 32'hFFFF9234);
        chk("sw_mem", {32'h0, mem_rd(32'h43), mem_rd(32'h42), mem_rd(32'h41), mem_rd(32'h40)},
            64'hDEADBEEF);
        run_txn(2'b11, 2'b00, 3'b010, 32'h40, 32'h0, 0, 6, 1'b1, 32'hDEADBEEF);
        run_txn(2'b11, 2'b00, 3'b010, 32'h42, 32'h0, 0, 2, 1'b1, 32'hDEADBEEF);
        run_txn(2'b01, 2'b01, 3'b000, 32'h10, 32'h0, 0, 2, 1'b1, 32'hDEADBEEF);
        run_txn(2'b00, 2'b00, 3'b000, 32'h10, 32'h0, 0, 2, 1'b1, 32'hDEADBEEF);
        run_txn(2'b01, 2'b00, 3'b000, 32'h10, 32'h0, 7, 6, 1'b1, 32'hDEADBEEF);

        // Reset in the middle of a word load
        @(negedge clk);
        cur_active = 1'b1; cur_we = 1'b0; cur_addr = 32'h80; cur_sd = 32'h0; cur_nbeats = 4;
        resp_beat = 0; resp_wait = 0;
        for (int i = 0; i < 4; i++) dly[i] = 0;
        read = 2'b11; write = 2'b00; func3 = 3'b010; addr = 32'h80; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (k < 20 && !(mem_req && mem_addr == 32'h82)) begin
            @(negedge clk);
            k++;
        end
        chk("rst_reach_beat2", {63'h0, (mem_req && mem_addr == 32'h82)}, 64'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_req_busy_done", {61'h0, mem_req, busy, done}, 64'h0);
        chk("midrst_load", {32'h0, load_data}, 64'h0);
        rst = 1'b0;
        cur_active = 1'b0;
        exp_load = 32'h0;
        @(negedge clk);
        chk("midrst_no_done", {63'h0, done}, 64'h0);
        run_txn(2'b01, 2'b00, 3'b000, 32'h103, 32'h0, 0, 3, 1'b1, 32'hFFFFFF80);

        for (int t = 0; t < 150; t++) begin
            r = int'($urandom % 8);
            a = 32'h100 + ($urandom % 64);
            sz = 2'(1 + $urandom % 3);
            if ($urandom % 2 == 0) begin
                if (sz == 2'b10) a[0] = 1'b0;
                if (sz == 2'b11) a[1:0] = 2'b00;
            end
            if (r == 0)
                run_txn(sz, 2'(1 + $urandom % 3), 3'($urandom), a, $urandom, -1, -1, 1'b0, 32'h0);
            else if (r == 1)
                run_txn(2'b00, 2'b00, 3'($urandom), a, $urandom, -1, -1, 1'b0, 32'h0);
            else if (r < 5)
                run_txn(sz, 2'b00, 3'($urandom), a, $urandom, -1, -1, 1'b0, 32'h0);
            else
                run_txn(2'b00, sz, 3'($urandom), a, $urandom, -1, -1, 1'b0, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
